// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer for a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (low half, then high half).
// Each half-word access lasts ACCESS_CYCLES clocks.
// The pipeline is frozen until the access finishes. In the single DONE cycle,
// freeze is released so that MEM/WB captures rdata.
module mem_stage_sequencer #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic [31:0]        stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t               state_r, state_s;
  logic [3:0]           cnt_r, cnt_s;
  logic                 op_wr_r, op_wr_s;
  logic [SRAM_AW-2:0]   word_r, word_s;
  logic [31:0]          wdata_r, wdata_s;
  logic [31:0]          rdata_r, rdata_s;
  logic [SRAM_AW-1:0]   sram_addr_r, sram_addr_s;
  logic [15:0]          dq_out_r, dq_out_s;
  logic                 we_n_r, we_n_s;
  logic                 oe_n_r, oe_n_s;
  logic [31:0]          stall_cnt_r, stall_cnt_s;
  logic                 req_s;
  logic                 last_s;
  logic                 freeze_s;
  logic                 unused_addr_s;

  // Only the word index of the byte address reaches the SRAM.
  assign unused_addr_s = ^{addr[31:SRAM_AW+1], addr[1:0]};

  assign req_s    = mem_r_en | mem_w_en;
  assign last_s   = (cnt_r == LAST_CNT);
  assign freeze_s = req_s & (state_r != DONE) & ~rst;

  // Next-state logic: the operation is latched in IDLE, then the counter paces LO and HI.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_wr_s = op_wr_r;
    word_s  = word_r;
    wdata_s = wdata_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = LO;
          cnt_s   = 4'd0;
          op_wr_s = mem_w_en;
          word_s  = addr[SRAM_AW:2];
          wdata_s = wdata;
        end else begin
          state_s = IDLE;
        end
      end
      LO: begin
        if (last_s) begin
          state_s = HI;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      HI: begin
        if (last_s) begin
          state_s = DONE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // SRAM pin values for the coming state, plus half-word capture into rdata on the last clock of each half.
  always_comb begin
    sram_addr_s = sram_addr_r;
    dq_out_s    = dq_out_r;
    we_n_s      = 1'b1;
    oe_n_s      = 1'b1;
    rdata_s     = rdata_r;
    case (state_s)
      LO: begin
        sram_addr_s = {word_s, 1'b0};
        dq_out_s    = wdata_s[15:0];
        we_n_s      = ~op_wr_s;
        oe_n_s      = op_wr_s;
      end
      HI: begin
        sram_addr_s = {word_s, 1'b1};
        dq_out_s    = wdata_s[31:16];
        we_n_s      = ~op_wr_s;
        oe_n_s      = op_wr_s;
      end
      default: begin
        we_n_s = 1'b1;
        oe_n_s = 1'b1;
      end
    endcase
    if ((state_r == LO) && last_s && !op_wr_r) begin
      rdata_s[15:0] = sram_dq_in;
    end else if ((state_r == HI) && last_s && !op_wr_r) begin
      rdata_s[31:16] = sram_dq_in;
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Stall counter: increments while frozen and saturates at all-ones instead of wrapping.
  always_comb begin
    if (freeze_s) begin
      if (stall_cnt_r == 32'hFFFF_FFFF) begin
        stall_cnt_s = stall_cnt_r;
      end else begin
        stall_cnt_s = stall_cnt_r + 32'd1;
      end
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // Sequencer state registers. Reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_wr_r <= 1'b0;
      word_r  <= {(SRAM_AW-1){1'b0}};
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_wr_r <= op_wr_s;
      word_r  <= word_s;
      wdata_r <= wdata_s;
    end
  end

  // Registered SRAM pins and load data. The strobes return high on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_r <= {SRAM_AW{1'b0}};
      dq_out_r    <= 16'd0;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      rdata_r     <= 32'd0;
    end else begin
      sram_addr_r <= sram_addr_s;
      dq_out_r    <= dq_out_s;
      we_n_r      <= we_n_s;
      oe_n_r      <= oe_n_s;
      rdata_r     <= rdata_s;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign rdata       = rdata_r;
  assign freeze      = freeze_s;
  assign sram_addr   = sram_addr_r;
  assign sram_dq_out = dq_out_r;
  assign sram_we_n   = we_n_r;
  assign sram_oe_n   = oe_n_r;
  assign stall_count = stall_cnt_r;

endmodule

// File: doc/mem_stage_sequencer.md
Name: mem_stage_sequencer

Overview:
- Sequences the MEM stage of the 5-stage MIPS pipeline onto an external 16-bit asynchronous SRAM.
- Splits each 32-bit load/store into two half-word SRAM accesses of fixed latency.
- Holds the pipeline (freeze) until the access completes, then presents the load word to the MEM/WB pipeline register for capture on the release edge.
- Counts stall cycles for performance monitoring.

Parameters:
- ACCESS_CYCLES, 2: clocks per half-word SRAM access; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- mem_r_en  input  1  load request from EX/MEM register
- mem_w_en  input  1  store request from EX/MEM register
- addr  input  32  byte address (word-aligned; addr[1:0] ignored)
- wdata  input  32  store data
- rdata  output  32  load data, valid in DONE cycle
- freeze  output  1  pipeline hold, combinational
- sram_addr  output  SRAM_AW  half-word address
- sram_dq_out  output  16  write data to SRAM
- sram_dq_in  input  16  read data from SRAM
- sram_we_n  output  1  active-low write strobe
- sram_oe_n  output  1  active-low output enable
- stall_count  output  32  saturating count of freeze-high cycles

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cycle counter=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_we_n=1, sram_oe_n=1, stall_count=0. freeze forced 0 while rst=1.
- Reset mid-access aborts the access: we_n deasserts on the reset edge and no partial rdata update survives.
- Request decode: req = mem_r_en | mem_w_en. Both asserted means a write; mem_r_en is ignored.
- States: IDLE, LO, HI, DONE.
  - IDLE: on req, latch op (rd/wr), word address and wdata; go to LO with counter=0.
  - LO: drive the low half-word for ACCESS_CYCLES clocks.
  - HI: drive the high half-word for ACCESS_CYCLES clocks.
  - DONE: lasts exactly 1 clock, then returns to IDLE.
- Counter behaviour in LO/HI: counter increments each clock. When counter==ACCESS_CYCLES-1, advance (LO->HI, HI->DONE) and clear the counter.
- Address mapping: word = addr[SRAM_AW:2].
  - LO: sram_addr = {word,1'b0}.
  - HI: sram_addr = {word,1'b1}.
- SRAM controls:
  - Writes: sram_we_n=0 and sram_oe_n=1 throughout LO/HI. sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - Reads: sram_oe_n=0 and sram_we_n=1 in LO/HI.
  - IDLE/DONE: both strobes high.
- Read capture: sample sram_dq_in on the last LO clock into rdata[15:0], and on the last HI clock into rdata[31:16]. rdata holds until the next read completes; writes leave rdata unchanged.
- freeze = req & (state != DONE) & ~rst.
  - Asserts in the same cycle the request first appears, including in IDLE.
  - Low in DONE, so the pipeline advances and MEM/WB captures rdata on that edge.
  - Total freeze = 2*ACCESS_CYCLES+1 cycles (IDLE cycle + LO + HI), then 1 DONE cycle.
- Back-to-back memory ops: the next op arrives while in IDLE after DONE. No idle bubble beyond DONE is inserted.
- Request removed mid-access (flush): the access still completes to DONE; freeze drops immediately since req=0.
- stall_count increments every cycle freeze=1 and saturates at 0xFFFF_FFFF.

Test Plan:
- Read, ACCESS_CYCLES=2, addr=0x0000_0008, SRAM returns 0x1234 at half 4 and 0xABCD at half 5 -> sram_addr 4,4 then 5,5; oe_n low 4 clocks; freeze high 5 cycles, low in DONE; rdata=0xABCD_1234; stall_count=5.
- Write, addr=0x0000_0010, wdata=0xDEAD_BEEF -> we_n low 4 clocks; dq_out 0xBEEF at sram_addr 8, 0xDEAD at 9; rdata unchanged; freeze 5 cycles.
- mem_r_en=mem_w_en=1 -> treated as write: we_n low, oe_n high throughout.
- Back-to-back read then write -> DONE then the write begins IDLE next cycle; freeze pattern 5 high, 1 low, 5 high.
- rst asserted during HI of a write -> next cycle we_n=1, state IDLE, freeze=0 while rst high, stall_count=0.
- ACCESS_CYCLES=1 read -> 3 freeze cycles; rdata correct; saturate check with stall_count preloaded via force to 0xFFFF_FFFE -> holds at 0xFFFF_FFFF.
